// File: rtl/cacheline_adaptor_pkg.sv
// Shared widths, types and FSM state encoding for the cacheline adaptor.
// One 256-bit cache line moves as four 64-bit memory beats.
package cacheline_adaptor_pkg;

    localparam int LINE_W      = 256;
    localparam int BURST_W     = 64;
    localparam int ADDR_W      = 32;
    localparam int BEATS       = LINE_W / BURST_W;
    localparam int OFFSET_BITS = $clog2(LINE_W / 8);
    localparam int CNT_W       = $clog2(BEATS);

    typedef logic [LINE_W-1:0]  line_t;
    typedef logic [BURST_W-1:0] burst_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DONE  = 3'd2,
        WR_BURST = 3'd3,
        WR_DONE  = 3'd4
    } adaptor_state_t;

    localparam addr_t LINE_ADDR_MASK = ~addr_t'((1 << OFFSET_BITS) - 1);

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one full-line read/write request from the arbiter into a fixed
// four-beat burst toward main memory, returning a single-cycle completion.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a request; write_i wins over read_i
// RD_BURST | read_o high, capture beats on resp_i; one drain cycle after
// RD_DONE  | resp_o pulse, assembled line presented on line_o
// WR_BURST | write_o high, present beats on burst_o; one drain cycle after
// WR_DONE  | resp_o pulse
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    adaptor_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    addr_t            addr_q;
    line_t            buf_q;
    line_t            line_q;
    logic             in_burst;
    logic             beat_fire;

    assign in_burst  = (state_q == RD_BURST) || (state_q == WR_BURST);
    // last_q marks the drain cycle after the final beat; no further beats are taken
    assign beat_fire = in_burst && !last_q && resp_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    state_d = WR_BURST;
                end else if (read_i) begin
                    state_d = RD_BURST;
                end
            end
            RD_BURST: if (last_q) state_d = RD_DONE;
            RD_DONE:  state_d = IDLE;
            WR_BURST: if (last_q) state_d = WR_DONE;
            WR_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_o  = 1'b0;
        read_o  = 1'b0;
        write_o = 1'b0;
        burst_o = '0;
        case (state_q)
            RD_BURST: read_o = !last_q;
            WR_BURST: begin
                write_o = !last_q;
                if (!last_q) begin
                    burst_o = buf_q[int'(cnt_q)*BURST_W +: BURST_W];
                end
            end
            RD_DONE,
            WR_DONE:  resp_o = 1'b1;
            default:  resp_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
            addr_q <= '0;
            buf_q  <= '0;
            line_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (write_i) begin
                    addr_q <= address_i;
                    buf_q  <= line_i;
                    cnt_q  <= '0;
                    last_q <= 1'b0;
                end else if (read_i) begin
                    addr_q <= address_i;
                    cnt_q  <= '0;
                    last_q <= 1'b0;
                end
            end
            if (beat_fire) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BEATS - 1)) begin
                    last_q <= 1'b1;
                end
                if (state_q == RD_BURST) begin
                    buf_q[int'(cnt_q)*BURST_W +: BURST_W] <= burst_i;
                end
            end
            // line_o only changes when a read completes, so it holds across writes
            if ((state_q == RD_BURST) && last_q) begin
                line_q <= buf_q;
            end
        end
    end

    assign address_o = addr_q & LINE_ADDR_MASK;
    assign line_o    = line_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, writes, gaps, collisions,
// reset mid-burst, stray resp_i and back-to-back requests.
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    line_t  line_i, line_o;
    addr_t  address_i, address_o;
    logic   read_i, write_i, resp_o;
    burst_t burst_i, burst_o;
    logic   read_o, write_o, resp_i;

    int n_pass  = 0;
    int n_total = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issues a read at cycle 0 and returns positioned in the resp_o cycle (cycle 6).
    task automatic run_read(input addr_t addr, input addr_t exp_addr, input line_t data, input bit hold);
        read_i    = 1'b1;
        address_i = addr;
        step();
        if (!hold) read_i = 1'b0;
        address_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rd_read_o_beat%0d", i), 256'(read_o), 256'd1);
            chk($sformatf("rd_addr_beat%0d", i), 256'(address_o), 256'(exp_addr));
            chk($sformatf("rd_resp_o_beat%0d", i), 256'(resp_o), 256'd0);
            resp_i  = 1'b1;
            burst_i = data[i*64 +: 64];
            step();
        end
        resp_i  = 1'b0;
        burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        chk("rd_drain_read_o", 256'(read_o), 256'd0);
        chk("rd_drain_resp_o", 256'(resp_o), 256'd0);
        step();
        chk("rd_resp_o", 256'(resp_o), 256'd1);
        chk("rd_line_o", line_o, data);
    endtask

    // Issues a write at cycle 0 (optionally with read_i too); returns in the resp_o cycle.
    task automatic run_write(input addr_t addr, input line_t data, input bit also_read);
        write_i   = 1'b1;
        read_i    = also_read;
        address_i = addr;
        line_i    = data;
        step();
        write_i   = 1'b0;
        read_i    = 1'b0;
        line_i    = ~data;
        address_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr_write_o_beat%0d", i), 256'(write_o), 256'd1);
            chk($sformatf("wr_read_o_beat%0d", i), 256'(read_o), 256'd0);
            chk($sformatf("wr_burst_o_beat%0d", i), 256'(burst_o), 256'(data[i*64 +: 64]));
            chk($sformatf("wr_addr_beat%0d", i), 256'(address_o), 256'(addr & 32'hFFFF_FFE0));
            resp_i = 1'b1;
            step();
        end
        resp_i = 1'b0;
        chk("wr_drain_write_o", 256'(write_o), 256'd0);
        chk("wr_drain_resp_o", 256'(resp_o), 256'd0);
        step();
        chk("wr_resp_o", 256'(resp_o), 256'd1);
    endtask

    line_t l1, lw, lg, lw2, l3, l4, l5, lw3, l_before;
    bit    pat[7];
    int    k;

    initial begin
        l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        lw  = {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
               64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000};
        lg  = {64'hA4A4_A4A4_0000_0004, 64'hA3A3_A3A3_0000_0003,
               64'hA2A2_A2A2_0000_0002, 64'hA1A1_A1A1_0000_0001};
        lw2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
        l3  = {64'hC4C4_C4C4_C4C4_C4C4, 64'hC3C3_C3C3_C3C3_C3C3,
               64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1};
        l4  = {64'h0000_0000_0000_0040, 64'h0000_0000_0000_0030,
               64'h0000_0000_0000_0020, 64'h0000_0000_0000_0010};
        l5  = {64'hE4E4_0000_0000_0000, 64'hE3E3_0000_0000_0000,
               64'hE2E2_0000_0000_0000, 64'hE1E1_0000_0000_0000};
        lw3 = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
               64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        line_i = '0; address_i = '0; burst_i = '0;
        step();
        step();
        chk("rst_resp_o", 256'(resp_o), 256'd0);
        chk("rst_read_o", 256'(read_o), 256'd0);
        chk("rst_write_o", 256'(write_o), 256'd0);
        chk("rst_burst_o", 256'(burst_o), 256'd0);
        chk("rst_address_o", 256'(address_o), 256'd0);
        chk("rst_line_o", line_o, 256'd0);
        rst = 1'b0;
        step();

        // read without gaps
        run_read(32'h0000_1234, 32'h0000_1220, l1, 1'b0);
        step();
        chk("rd1_resp_drop", 256'(resp_o), 256'd0);
        chk("rd1_line_hold", line_o, l1);

        // write without gaps; line_o must keep the last read line
        run_write(32'h8000_00E0, lw, 1'b0);
        chk("wr1_line_o_held", line_o, l1);
        step();
        chk("wr1_resp_drop", 256'(resp_o), 256'd0);

        // gapped read: resp_i 1,0,0,1,1,0,1
        read_i = 1'b1; address_i = 32'h0000_0047;
        step();
        read_i = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("gap_read_o_c%0d", i + 1), 256'(read_o), 256'd1);
            chk($sformatf("gap_resp_o_c%0d", i + 1), 256'(resp_o), 256'd0);
            resp_i  = pat[i];
            burst_i = pat[i] ? lg[k*64 +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
            if (pat[i]) k++;
            step();
        end
        resp_i = 1'b0;
        chk("gap_drain_read_o", 256'(read_o), 256'd0);
        chk("gap_drain_resp_o", 256'(resp_o), 256'd0);
        step();
        chk("gap_resp_o", 256'(resp_o), 256'd1);
        chk("gap_line_o", line_o, lg);
        chk("gap_address_o", 256'(address_o), 256'h40);
        step();

        // read_i and write_i together: write wins
        run_write(32'h1234_567F, lw2, 1'b1);
        step();

        // reset after two read beats
        read_i = 1'b1; address_i = 32'h0000_0100;
        step();
        read_i = 1'b0;
        resp_i = 1'b1; burst_i = 64'h9999_9999_9999_9999;
        step();
        burst_i = 64'h8888_8888_8888_8888;
        step();
        resp_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_read_o", 256'(read_o), 256'd0);
        chk("rstmid_resp_o", 256'(resp_o), 256'd0);
        chk("rstmid_address_o", 256'(address_o), 256'd0);
        chk("rstmid_line_o", line_o, 256'd0);
        step();
        chk("rstmid_idle_read_o", 256'(read_o), 256'd0);
        chk("rstmid_idle_resp_o", 256'(resp_o), 256'd0);
        run_read(32'h0000_0120, 32'h0000_0120, l3, 1'b0);
        step();

        // stray resp_i while idle
        resp_i = 1'b1; burst_i = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stray_resp_o_%0d", i), 256'(resp_o), 256'd0);
            chk($sformatf("stray_read_o_%0d", i), 256'(read_o), 256'd0);
            chk($sformatf("stray_write_o_%0d", i), 256'(write_o), 256'd0);
        end
        resp_i = 1'b0;
        l_before = line_o;
        chk("stray_line_o_held", line_o, l3);
        run_read(32'h0000_2001, 32'h0000_2000, l4, 1'b0);
        step();

        // back-to-back: read held through resp_o, then write issued
        run_read(32'h0000_3010, 32'h0000_3000, l5, 1'b1);
        step();
        chk("b2b_no_retrigger_read_o", 256'(read_o), 256'd0);
        chk("b2b_resp_o_single", 256'(resp_o), 256'd0);
        read_i = 1'b0;
        run_write(32'h0000_4000, lw3, 1'b0);
        step();
        chk("b2b_final_resp_drop", 256'(resp_o), 256'd0);
        chk("b2b_final_idle_write_o", 256'(write_o), 256'd0);
        chk("b2b_line_o", line_o, l5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
